// File: rtl/axi_write_burst_scheduler_if.sv
// Bundles the merger-FIFO head/dequeue signals and the AXI4-Stream write master
// driven by the write burst scheduler.
interface axi_write_burst_scheduler_if #(
   parameter int C_DATA_WIDTH = 512,
   parameter int C_NUM_SRC    = 4
) ();
   logic [C_NUM_SRC-1:0]              src_valid;
   logic [C_NUM_SRC*C_DATA_WIDTH-1:0] src_item;
   logic [C_NUM_SRC-1:0]              src_deq;
   logic                              m_axis_tvalid;
   logic                              m_axis_tready;
   logic [C_DATA_WIDTH-1:0]           m_axis_tdata;
   logic [C_DATA_WIDTH/8-1:0]         m_axis_tkeep;
   logic                              m_axis_tlast;
   logic [3:0]                        m_axis_tid;

   modport master (
      input  src_valid, src_item, m_axis_tready,
      output src_deq, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid
   );

   modport slave (
      output src_valid, src_item, m_axis_tready,
      input  src_deq, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid
   );
endinterface

// File: rtl/axi_write_burst_scheduler.sv
// Round-robin scheduler sharing one AXI4-Stream write master among several merger
// output FIFOs, issuing atomic bursts and turning zero-key terminators into null tlast beats.
module axi_write_burst_scheduler #(
   parameter int C_AXIS_TDATA_WIDTH = 512,
   parameter int C_SORTER_BIT_WIDTH = 512,
   parameter int C_NUM_SRC          = 4,
   parameter int C_BURST_LEN        = 16
) (
   input  logic                       m_axis_aclk,
   input  logic                       m_axis_aresetn,
   input  logic                       start,
   axi_write_burst_scheduler_if.master bus,
   output logic                       all_done,
   output logic [31:0]                beat_count
);
   localparam int W  = C_SORTER_BIT_WIDTH;
   localparam int GW = $clog2(C_NUM_SRC);
   localparam int BW = $clog2(C_BURST_LEN);
   localparam logic [BW-1:0] LAST_BEAT = BW'(C_BURST_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARB,
      ST_STREAM,
      ST_DONE
   } state_t;

   state_t                      state;
   logic [C_NUM_SRC-1:0]        done_mask;
   logic [GW-1:0]               grant;
   logic [GW-1:0]               last_grant;
   logic [BW-1:0]               beat_cnt;

   logic                        tvalid_q;
   logic [C_AXIS_TDATA_WIDTH-1:0]   tdata_q;
   logic [C_AXIS_TDATA_WIDTH/8-1:0] tkeep_q;
   logic                        tlast_q;
   logic [3:0]                  tid_q;

   logic                        found;
   logic [GW-1:0]               pick;
   logic [GW-1:0]               cand;
   logic [W-1:0]                grant_item;
   logic                        key_zero;
   logic                        space;
   logic                        deq_fire;
   logic [C_NUM_SRC-1:0]        src_deq_c;

   // Round-robin search starting just after the last granted source.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 1; k <= C_NUM_SRC; k++) begin
         cand = GW'((int'(last_grant) + k) % C_NUM_SRC);
         if (!found && bus.src_valid[cand] && !done_mask[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      grant_item = bus.src_item[grant*W +: W];
      key_zero   = (grant_item[31:0] == 32'd0);
      space      = !tvalid_q || bus.m_axis_tready;
      deq_fire   = (state == ST_STREAM) && space && bus.src_valid[grant];
      src_deq_c  = '0;
      if (deq_fire) begin
         src_deq_c[grant] = 1'b1;
      end
   end

   assign bus.src_deq       = src_deq_c;
   assign bus.m_axis_tvalid = tvalid_q;
   assign bus.m_axis_tdata  = tdata_q;
   assign bus.m_axis_tkeep  = tkeep_q;
   assign bus.m_axis_tlast  = tlast_q;
   assign bus.m_axis_tid    = tid_q;

   // Scheduler FSM together with the single-entry output register; a dequeue always
   // refills the register, otherwise an accepted beat empties it.
   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         state      <= ST_IDLE;
         done_mask  <= '0;
         grant      <= '0;
         last_grant <= GW'(C_NUM_SRC - 1);
         beat_cnt   <= '0;
         tvalid_q   <= 1'b0;
         tdata_q    <= '0;
         tkeep_q    <= '0;
         tlast_q    <= 1'b0;
         tid_q      <= '0;
         all_done   <= 1'b0;
         beat_count <= '0;
      end else begin
         if (tvalid_q && bus.m_axis_tready && (tkeep_q != '0)) begin
            beat_count <= beat_count + 32'd1;
         end

         if (deq_fire) begin
            tvalid_q <= 1'b1;
            tid_q    <= 4'(grant);
            if (key_zero) begin
               tdata_q <= '0;
               tkeep_q <= '0;
               tlast_q <= 1'b1;
            end else begin
               tdata_q <= C_AXIS_TDATA_WIDTH'(grant_item);
               tkeep_q <= '1;
               tlast_q <= (beat_cnt == LAST_BEAT);
            end
         end else if (bus.m_axis_tready) begin
            tvalid_q <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  done_mask  <= '0;
                  beat_count <= '0;
                  state      <= ST_ARB;
               end
            end
            ST_ARB: begin
               // The run only finishes once the final terminator beat has left.
               if (&done_mask) begin
                  if (space) begin
                     all_done <= 1'b1;
                     state    <= ST_DONE;
                  end
               end else if (found) begin
                  grant      <= pick;
                  last_grant <= pick;
                  beat_cnt   <= '0;
                  state      <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (deq_fire) begin
                  if (key_zero) begin
                     done_mask[grant] <= 1'b1;
                     state            <= ST_ARB;
                  end else begin
                     beat_cnt <= beat_cnt + BW'(1);
                     if (beat_cnt == LAST_BEAT) begin
                        state <= ST_ARB;
                     end
                  end
               end
            end
            ST_DONE: begin
               if (start) begin
                  done_mask  <= '0;
                  beat_count <= '0;
                  all_done   <= 1'b0;
                  state      <= ST_ARB;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_write_burst_scheduler.sv
// Randomized bench for the write burst scheduler: source FIFOs are queues and the
// expected beat stream comes from a round-robin burst model over those queues.
module tb_axi_write_burst_scheduler;
   localparam int W  = 64;
   localparam int N  = 4;
   localparam int L  = 4;
   localparam int KW = W / 8;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [KW-1:0] keep;
      logic          last;
      logic [3:0]    id;
   } beat_t;

   typedef logic [W-1:0] item_q_t[$];

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        all_done;
   logic [31:0] beat_count;

   always #5 clk = ~clk;

   axi_write_burst_scheduler_if #(.C_DATA_WIDTH(W), .C_NUM_SRC(N)) bus ();

   axi_write_burst_scheduler #(
      .C_AXIS_TDATA_WIDTH(W),
      .C_SORTER_BIT_WIDTH(W),
      .C_NUM_SRC(N),
      .C_BURST_LEN(L)
   ) dut (
      .m_axis_aclk   (clk),
      .m_axis_aresetn(rst_n),
      .start         (start),
      .bus           (bus),
      .all_done      (all_done),
      .beat_count    (beat_count)
   );

   item_q_t srcq[N];
   item_q_t mq[N];
   item_q_t saved[N];
   bit      gate[N];
   bit      mdone[N];
   int      model_last;
   beat_t   exp_q[$];
   beat_t   obs_q[$];
   int      deq_cnt[N];
   int      deq_viol;
   int      stall_viol;
   bit      held_valid;
   beat_t   held_beat;
   bit      tready_rand;
   int      checks = 0;
   int      failures = 0;

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         bus.src_valid[i]        = gate[i] && (srcq[i].size() > 0);
         bus.src_item[i*W +: W]  = (srcq[i].size() > 0) ? srcq[i][0] : '0;
      end
   endtask

   task automatic load_src(input int i, input int n);
      logic [W-1:0] it;
      for (int k = 0; k < n; k++) begin
         it = {$urandom, $urandom};
         if (it[31:0] == 32'd0) it[0] = 1'b1;
         srcq[i].push_back(it);
         mq[i].push_back(it);
      end
      it = {$urandom, 32'd0};
      srcq[i].push_back(it);
      mq[i].push_back(it);
      drive_inputs();
   endtask

   // Reference: pick the next unfinished non-empty source after the last grant, emit up
   // to L data beats (tlast on the L-th) or stop early at a terminator with a null tlast.
   task automatic build_expected();
      int g;
      int cnt;
      bit fnd;
      logic [W-1:0] it;
      beat_t b;
      while (1) begin
         fnd = 1'b0;
         g = 0;
         for (int k = 1; k <= N; k++) begin
            int i;
            i = (model_last + k) % N;
            if (!fnd && !mdone[i] && mq[i].size() > 0) begin
               fnd = 1'b1;
               g = i;
            end
         end
         if (!fnd) break;
         model_last = g;
         cnt = 0;
         while (cnt < L && mq[g].size() > 0) begin
            it = mq[g].pop_front();
            b.id = 4'(g);
            if (it[31:0] == 32'd0) begin
               b.data = '0;
               b.keep = '0;
               b.last = 1'b1;
               exp_q.push_back(b);
               mdone[g] = 1'b1;
               break;
            end
            cnt++;
            b.data = it;
            b.keep = '1;
            b.last = (cnt == L);
            exp_q.push_back(b);
         end
      end
   endtask

   // One clock: observe at the falling edge, then apply handshake effects after the rise.
   task automatic cycle();
      logic [N-1:0] d;
      bit acc;
      beat_t b;
      @(negedge clk);
      d   = bus.src_deq;
      acc = bus.m_axis_tvalid && bus.m_axis_tready;
      b   = {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tid};
      if (d != '0 && (!$onehot(d) || (d & ~bus.src_valid) != '0)) deq_viol++;
      if (held_valid && (!bus.m_axis_tvalid || b != held_beat)) stall_viol++;
      held_valid = bus.m_axis_tvalid && !bus.m_axis_tready;
      held_beat  = b;
      @(posedge clk);
      #1;
      if (acc) obs_q.push_back(b);
      for (int i = 0; i < N; i++) begin
         if (d[i]) begin
            deq_cnt[i]++;
            if (srcq[i].size() > 0) void'(srcq[i].pop_front());
         end
      end
      if (tready_rand) bus.m_axis_tready = 1'($urandom_range(0, 1));
      drive_inputs();
   endtask

   task automatic run_beats(input int n, input int max_cycles, output bit ok);
      int c;
      c = 0;
      while (obs_q.size() < n && c < max_cycles) begin
         cycle();
         c++;
      end
      ok = (obs_q.size() >= n);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      start = 1'b0;
      bus.m_axis_tready = 1'b1;
      tready_rand = 1'b0;
      for (int i = 0; i < N; i++) begin
         gate[i] = 1'b1;
         mdone[i] = 1'b0;
         deq_cnt[i] = 0;
         srcq[i].delete();
         mq[i].delete();
      end
      exp_q.delete();
      obs_q.delete();
      held_valid = 1'b0;
      deq_viol = 0;
      stall_viol = 0;
      model_last = N - 1;
      drive_inputs();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < N; i++) mdone[i] = 1'b0;
   endtask

   function automatic int data_beats();
      int nd;
      nd = 0;
      foreach (exp_q[k]) if (exp_q[k].keep != '0) nd++;
      return nd;
   endfunction

   task automatic test_reset();
      apply_reset();
      load_src(0, 3);
      checks++;
      if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tlast !== 1'b0 || bus.m_axis_tid !== 4'd0) begin
         failures++;
         $display("[TB] FAIL reset_ctrl: tvalid=%b tlast=%b tid=%0d, required 0 0 0", bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tid);
      end
      checks++;
      if (bus.m_axis_tdata !== '0 || bus.m_axis_tkeep !== '0) begin
         failures++;
         $display("[TB] FAIL reset_data: tdata=%h tkeep=%h, required 0", bus.m_axis_tdata, bus.m_axis_tkeep);
      end
      checks++;
      if (all_done !== 1'b0 || beat_count !== 32'd0) begin
         failures++;
         $display("[TB] FAIL reset_status: all_done=%b beat_count=%0d, required 0 0", all_done, beat_count);
      end
      repeat (6) cycle();
      checks++;
      if (deq_cnt[0] !== 0 || obs_q.size() !== 0) begin
         failures++;
         $display("[TB] FAIL idle_no_deq: deq=%0d beats=%0d, required 0 0", deq_cnt[0], obs_q.size());
      end
   endtask

   task automatic test_single_source();
      bit ok;
      apply_reset();
      load_src(0, 10);
      pulse_start();
      build_expected();
      run_beats(exp_q.size(), 300, ok);
      repeat (8) cycle();
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL t1_timeout: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
            failures++;
            $display("[TB] FAIL t1_beat[%0d]: got %h, required %h", k, (k < obs_q.size()) ? obs_q[k] : '0, exp_q[k]);
         end
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL t1_count: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
      checks++;
      if (beat_count !== 32'd10 || all_done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL t1_status: beat_count=%0d all_done=%b, required 10 0", beat_count, all_done);
      end
   endtask

   task automatic test_all_sources();
      bit ok;
      apply_reset();
      for (int i = 0; i < N; i++) load_src(i, 8);
      pulse_start();
      build_expected();
      run_beats(exp_q.size(), 400, ok);
      repeat (8) cycle();
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL t2_timeout: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
            failures++;
            $display("[TB] FAIL t2_beat[%0d]: got %h, required %h", k, (k < obs_q.size()) ? obs_q[k] : '0, exp_q[k]);
         end
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL t2_count: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
      checks++;
      if (beat_count !== 32'd32 || all_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL t2_status: beat_count=%0d all_done=%b, required 32 1", beat_count, all_done);
      end
      checks++;
      if (deq_viol !== 0) begin failures++; $display("[TB] FAIL t2_deq_rule: got %0d violations, required 0", deq_viol); end
   endtask

   task automatic test_backpressure();
      bit ok;
      apply_reset();
      tready_rand = 1'b1;
      for (int i = 0; i < N; i++) load_src(i, $urandom_range(3, 9));
      pulse_start();
      build_expected();
      run_beats(exp_q.size(), 2000, ok);
      tready_rand = 1'b0;
      bus.m_axis_tready = 1'b1;
      repeat (8) cycle();
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL t3_timeout: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
            failures++;
            $display("[TB] FAIL t3_beat[%0d]: got %h, required %h", k, (k < obs_q.size()) ? obs_q[k] : '0, exp_q[k]);
         end
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL t3_count: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
      checks++;
      if (stall_viol !== 0) begin failures++; $display("[TB] FAIL t3_stall_hold: got %0d violations, required 0", stall_viol); end
      checks++;
      if (beat_count !== 32'(data_beats()) || all_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL t3_status: beat_count=%0d all_done=%b, required %0d 1", beat_count, all_done, data_beats());
      end
   endtask

   task automatic test_source_gap();
      bit ok;
      int d2;
      apply_reset();
      load_src(1, 8);
      load_src(2, 8);
      pulse_start();
      build_expected();
      run_beats(2, 100, ok);
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL t4_first_beats: got %0d beats, required 2", obs_q.size()); end
      gate[1] = 1'b0;
      drive_inputs();
      d2 = deq_cnt[2];
      repeat (5) cycle();
      checks++;
      if (deq_cnt[2] !== d2 || obs_q.size() !== 3) begin
         failures++;
         $display("[TB] FAIL t4_no_switch: src2 deq=%0d beats=%0d, required 0 3", deq_cnt[2] - d2, obs_q.size());
      end
      gate[1] = 1'b1;
      drive_inputs();
      run_beats(exp_q.size(), 300, ok);
      repeat (8) cycle();
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL t4_timeout: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
            failures++;
            $display("[TB] FAIL t4_beat[%0d]: got %h, required %h", k, (k < obs_q.size()) ? obs_q[k] : '0, exp_q[k]);
         end
      end
      checks++;
      if (deq_viol !== 0 || obs_q.size() != exp_q.size()) begin
         failures++;
         $display("[TB] FAIL t4_tail: deq violations=%0d beats=%0d, required 0 %0d", deq_viol, obs_q.size(), exp_q.size());
      end
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      apply_reset();
      pulse_start();
      load_src(1, 8);
      run_beats(2, 100, ok);
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL t5_pre_reset: got %0d beats, required 2", obs_q.size()); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.m_axis_tvalid !== 1'b0 || bus.src_deq !== '0 || bus.m_axis_tkeep !== '0) begin
         failures++;
         $display("[TB] FAIL t5_async_clear: tvalid=%b src_deq=%b tkeep=%h, required 0", bus.m_axis_tvalid, bus.src_deq, bus.m_axis_tkeep);
      end
      apply_reset();
      for (int i = 0; i < N; i++) load_src(i, 2);
      pulse_start();
      build_expected();
      run_beats(exp_q.size(), 300, ok);
      repeat (8) cycle();
      checks++;
      if (obs_q.size() == 0 || obs_q[0].id !== 4'd0) begin
         failures++;
         $display("[TB] FAIL t5_first_grant: got tid %0d, required 0", (obs_q.size() > 0) ? obs_q[0].id : 4'hf);
      end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
            failures++;
            $display("[TB] FAIL t5_beat[%0d]: got %h, required %h", k, (k < obs_q.size()) ? obs_q[k] : '0, exp_q[k]);
         end
      end
      checks++;
      if (!ok || all_done !== 1'b1) begin failures++; $display("[TB] FAIL t5_done: beats=%0d all_done=%b, required %0d 1", obs_q.size(), all_done, exp_q.size()); end
   endtask

   task automatic test_start_rerun();
      bit ok;
      apply_reset();
      for (int i = 0; i < N; i++) begin
         load_src(i, 5);
         saved[i] = srcq[i];
      end
      pulse_start();
      build_expected();
      run_beats(2, 100, ok);
      start = 1'b1;
      cycle();
      start = 1'b0;
      run_beats(exp_q.size(), 400, ok);
      repeat (8) cycle();
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
            failures++;
            $display("[TB] FAIL t6_run1_beat[%0d]: got %h, required %h", k, (k < obs_q.size()) ? obs_q[k] : '0, exp_q[k]);
         end
      end
      checks++;
      if (!ok || beat_count !== 32'd20 || all_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL t6_run1_status: beat_count=%0d all_done=%b, required 20 1", beat_count, all_done);
      end
      pulse_start();
      checks++;
      if (beat_count !== 32'd0 || all_done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL t6_restart: beat_count=%0d all_done=%b, required 0 0", beat_count, all_done);
      end
      exp_q.delete();
      obs_q.delete();
      for (int i = 0; i < N; i++) begin
         srcq[i] = saved[i];
         mq[i] = saved[i];
      end
      drive_inputs();
      build_expected();
      run_beats(exp_q.size(), 400, ok);
      repeat (8) cycle();
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
            failures++;
            $display("[TB] FAIL t6_run2_beat[%0d]: got %h, required %h", k, (k < obs_q.size()) ? obs_q[k] : '0, exp_q[k]);
         end
      end
      checks++;
      if (!ok || beat_count !== 32'd20 || all_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL t6_run2_status: beat_count=%0d all_done=%b, required 20 1", beat_count, all_done);
      end
   endtask

   initial begin
      $display("[TB] starting axi_write_burst_scheduler bench");
      test_reset();
      test_single_source();
      test_all_sources();
      test_backpressure();
      test_source_gap();
      test_reset_mid_burst();
      test_start_rerun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
